muxpga_cfg_loader: RTL and testbench

- Configuration writer for the 4x4 mux-cell fabric.
- Receives a framed nibble stream from the 4-bit config pins and deserializes it into a shadow register of per-cell config bytes.
- Verifies an XOR checksum, then atomically commits the shadow register to the active config bus that drives the cells' input-select muxes and function selects.
- Sits between the top-level io_in pins and the cell array.

---
 rtl/muxpga_pkg.sv | 31 +++
 rtl/muxpga_cfg_shadow.sv | 31 +++
 rtl/muxpga_cfg_loader.sv | 104 ++++++++++
 tb/tb_muxpga_cfg_loader.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/muxpga_pkg.sv
// Shared definitions for the mux-cell fabric: geometry, sync nibble, config field
// layout, cell function encodings and the config loader state type.
package muxpga_pkg;

  localparam int CELLS     = 16;
  localparam int CELL_BITS = 8;
  localparam logic [3:0] SYNC = 4'hA;

  localparam int NIBS  = 2 * CELLS;
  localparam int CNT_W = $clog2(NIBS);
  localparam int CFG_W = CELLS * CELL_BITS;

  // Field offsets inside one cell config byte; bits [7:6] are reserved.
  localparam int IN1_LSB = 0;
  localparam int IN2_LSB = 2;
  localparam int FN_LSB  = 4;

  typedef enum logic [1:0] {
    FN_AND = 2'd0,
    FN_OR  = 2'd1,
    FN_IN1 = 2'd2,
    FN_IN2 = 2'd3
  } cell_fn_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CHECK = 2'd2
  } cfg_state_e;

endpackage

// File: rtl/muxpga_cfg_shadow.sv
// Nibble-addressed shadow register and the active config register it commits into.
// The active register only ever loads the whole shadow at once.
module muxpga_cfg_shadow
  import muxpga_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_addr,
  input  logic [3:0]       wr_data,
  input  logic             commit,
  output logic [CFG_W-1:0] cfg_out
);

  logic [CFG_W-1:0] shadow;

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow  <= '0;
      cfg_out <= '0;
    end else begin
      if (wr_en) begin
        shadow[wr_addr*4 +: 4] <= wr_data;
      end
      if (commit) begin
        cfg_out <= shadow;
      end
    end
  end

endmodule

// File: rtl/muxpga_cfg_loader.sv
// Framed nibble-stream config loader: SYNC, 2*CELLS data nibbles, XOR checksum nibble,
// then an atomic commit of the shadow register onto the active config bus.
module muxpga_cfg_loader
  import muxpga_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             nib_valid,
  input  logic [3:0]       nib,
  input  logic             abort,
  output logic [CFG_W-1:0] cfg_out,
  output logic             cfg_loaded,
  output logic             cfg_error,
  output logic             busy,
  output cfg_state_e       state_dbg
);

  // Handshake: the source has no backpressure; a nibble is consumed on every rising
  // edge where nib_valid is high, and abort wins over nib_valid in LOAD and CHECK.

  cfg_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       csum, csum_nxt;
  logic             wr_en, commit, err_set, err_clr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      csum       <= '0;
      cfg_loaded <= 1'b0;
      cfg_error  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      csum       <= csum_nxt;
      cfg_loaded <= commit;
      if (err_clr) begin
        cfg_error <= 1'b0;
      end else if (err_set) begin
        cfg_error <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    csum_nxt  = csum;
    wr_en     = 1'b0;
    commit    = 1'b0;
    err_set   = 1'b0;
    err_clr   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (nib_valid && nib == SYNC) begin
          state_nxt = ST_LOAD;
          cnt_nxt   = '0;
          csum_nxt  = '0;
          err_clr   = 1'b1;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (nib_valid) begin
          wr_en    = 1'b1;
          cnt_nxt  = cnt + 1'b1;
          csum_nxt = csum ^ nib;
          if (cnt == CNT_W'(NIBS - 1)) begin
            state_nxt = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (nib_valid) begin
          state_nxt = ST_IDLE;
          if (nib == csum) begin
            commit = 1'b1;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

  muxpga_cfg_shadow u_shadow (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (cnt),
    .wr_data (nib),
    .commit  (commit),
    .cfg_out (cfg_out)
  );

endmodule

// File: tb/tb_muxpga_cfg_loader.sv
// Directed bench for muxpga_cfg_loader: commits are predicted into a queue and checked
// by a monitor on each cfg_loaded pulse; flags and retention are checked inline.
module tb_muxpga_cfg_loader;
  import muxpga_pkg::*;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             nib_valid = 1'b0;
  logic [3:0]       nib = 4'h0;
  logic             abort = 1'b0;
  logic [CFG_W-1:0] cfg_out;
  logic             cfg_loaded;
  logic             cfg_error;
  logic             busy;
  cfg_state_e       state_dbg;

  int errors = 0;
  int checks = 0;
  logic [CFG_W-1:0] exp_q[$];
  logic [CFG_W-1:0] exp_active = '0;
  bit               check_busy = 1'b0;

  muxpga_cfg_loader dut (
    .clk        (clk),
    .reset      (reset),
    .nib_valid  (nib_valid),
    .nib        (nib),
    .abort      (abort),
    .cfg_out    (cfg_out),
    .cfg_loaded (cfg_loaded),
    .cfg_error  (cfg_error),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no end, required end of test");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [CFG_W-1:0] act, input logic [CFG_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Monitor: every cfg_loaded pulse must match the oldest predicted commit.
  always @(negedge clk) begin
    if (!reset && cfg_loaded) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL commit_unexpected: got cfg_loaded=1 cfg_out=%h required no commit", cfg_out);
      end else begin
        logic [CFG_W-1:0] e;
        e = exp_q.pop_front();
        if (cfg_out !== e || cfg_error !== 1'b0) begin
          errors++;
          $display("FAIL commit_data: got cfg_out=%h err=%b required %h err=0", cfg_out, cfg_error, e);
        end
      end
    end
  end

  task automatic idle_cycle();
    nib_valid = 1'b0;
    @(posedge clk);
    #1;
    if (check_busy) chk("busy_in_gap", CFG_W'(busy), CFG_W'(1'b1));
  endtask

  task automatic send_nib(input logic [3:0] n);
    nib_valid = 1'b1;
    nib       = n;
    @(posedge clk);
    #1;
    nib_valid = 1'b0;
  endtask

  function automatic logic [3:0] calc_csum(input logic [CFG_W-1:0] cfg);
    logic [3:0] c;
    c = 4'h0;
    for (int i = 0; i < NIBS; i++) c = c ^ cfg[i*4 +: 4];
    return c;
  endfunction

  task automatic send_frame(input logic [CFG_W-1:0] cfg, input logic [3:0] cs,
                            input int max_gap, input bit good);
    send_nib(SYNC);
    for (int i = 0; i < NIBS; i++) begin
      repeat ($urandom_range(0, max_gap)) idle_cycle();
      send_nib(cfg[i*4 +: 4]);
    end
    repeat ($urandom_range(0, max_gap)) idle_cycle();
    if (good) begin
      exp_q.push_back(cfg);
      exp_active = cfg;
    end
    send_nib(cs);
  endtask

  initial begin
    logic [CFG_W-1:0] f;

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_cfg_out", cfg_out, '0);
    chk("reset_loaded", CFG_W'(cfg_loaded), '0);
    chk("reset_error", CFG_W'(cfg_error), '0);
    chk("reset_busy", CFG_W'(busy), '0);

    // Nominal: 16 cells of 0x5A, checksum 0.
    f = {CELLS{8'h5A}};
    send_frame(f, 4'h0, 0, 1'b1);
    chk("nominal_cfg_out", cfg_out, {CELLS{8'h5A}});
    chk("nominal_error", CFG_W'(cfg_error), '0);
    chk("nominal_busy", CFG_W'(busy), '0);
    idle_cycle();
    chk("loaded_one_cycle", CFG_W'(cfg_loaded), '0);

    // Bad checksum then corrected resend.
    f = '0;
    f[7:0] = 8'h01;
    send_frame(f, 4'h0, 0, 1'b0);
    chk("bad_error_set", CFG_W'(cfg_error), CFG_W'(1'b1));
    chk("bad_cfg_retained", cfg_out, {CELLS{8'h5A}});
    idle_cycle();
    chk("bad_no_loaded", CFG_W'(cfg_loaded), '0);
    send_nib(SYNC);
    chk("sync_clears_error", CFG_W'(cfg_error), '0);
    chk("sync_busy", CFG_W'(busy), CFG_W'(1'b1));
    for (int i = 0; i < NIBS; i++) send_nib(f[i*4 +: 4]);
    exp_q.push_back(f);
    exp_active = f;
    send_nib(4'h1);
    chk("resend_cfg_out", cfg_out, f);

    // Gapped stream with busy checked in every gap.
    f = 128'h0123456789ABCDEF_FEDCBA9876543210;
    check_busy = 1'b1;
    send_frame(f, 4'h0, 5, 1'b1);
    check_busy = 1'b0;
    chk("gapped_cfg_out", cfg_out, f);
    chk("gapped_error", CFG_W'(cfg_error), '0);

    // Abort together with nibble 17.
    send_nib(SYNC);
    for (int i = 0; i < 17; i++) send_nib(4'h7);
    abort = 1'b1;
    send_nib(4'h3);
    abort = 1'b0;
    chk("abort_busy", CFG_W'(busy), '0);
    chk("abort_error", CFG_W'(cfg_error), '0);
    chk("abort_cfg_retained", cfg_out, exp_active);
    idle_cycle();
    chk("abort_no_loaded", CFG_W'(cfg_loaded), '0);
    f = {8{16'h2107}};
    send_frame(f, calc_csum(f), 0, 1'b1);
    chk("after_abort_cfg_out", cfg_out, f);

    // Reset at nibble 10.
    send_nib(SYNC);
    for (int i = 0; i < 10; i++) send_nib(4'h9);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_active = '0;
    chk("midreset_cfg_out", cfg_out, '0);
    chk("midreset_busy", CFG_W'(busy), '0);
    idle_cycle();
    chk("midreset_cfg_hold", cfg_out, '0);
    f = {CELLS{8'hC3}};
    send_frame(f, 4'h0, 2, 1'b1);
    chk("postreset_cfg_out", cfg_out, {CELLS{8'hC3}});

    // Data equal to SYNC, then a back-to-back all-zero frame.
    f = {CELLS{8'hAA}};
    send_frame(f, 4'h0, 0, 1'b1);
    chk("sync_data_cfg_out", cfg_out, {CELLS{8'hAA}});
    f = '0;
    send_frame(f, 4'h0, 0, 1'b1);
    chk("b2b_cfg_out", cfg_out, '0);
    idle_cycle();
    idle_cycle();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL commits_missing: got %0d pending, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
